// File: rtl/uart_baud_gen.sv
// Baud-rate generator: integer-plus-fraction clock divider producing an
// oversample tick, a per-bit transmit pulse and the current oversample phase.
module uart_baud_gen #(
  parameter int BAUD_WIDTH = 16,
  parameter int FRAC_WIDTH = 3,
  parameter int OVS_LOG2   = 4
) (
  input  logic                                           CLK,
  input  logic                                           RESET_N,
  input  logic                                           EN,
  input  logic [BAUD_WIDTH-1:0]                          BAUD_VAL,
  input  logic [((FRAC_WIDTH > 0) ? FRAC_WIDTH : 1)-1:0] BAUD_FRAC,
  input  logic                                           OVS_SYNC,
  output logic                                           BAUD_TICK,
  output logic                                           XMIT_PULSE,
  output logic [OVS_LOG2-1:0]                            OVS_PHASE
);

  // One extra bit so BAUD_VAL plus a fraction carry can never wrap.
  localparam int CW = BAUD_WIDTH + 1;

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [OVS_LOG2-1:0] ovs;
  logic [OVS_LOG2-1:0] ovs_nxt;
  logic                tick_r;
  logic                tick_nxt;
  logic                xmit_r;
  logic                xmit_nxt;
  logic                carry;
  logic                div_event;
  logic                sync_load;

  assign sync_load = EN & OVS_SYNC;
  assign div_event = EN & ~OVS_SYNC & (cnt == '0);

  generate
    if (FRAC_WIDTH > 0) begin : g_frac
      logic [FRAC_WIDTH-1:0] acc;
      logic [FRAC_WIDTH:0]   frac_sum;

      assign frac_sum = {1'b0, acc} + {1'b0, BAUD_FRAC};
      assign carry    = frac_sum[FRAC_WIDTH];

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          acc <= '0;
        end else if (sync_load) begin
          acc <= '0;
        end else if (div_event) begin
          acc <= frac_sum[FRAC_WIDTH-1:0];
        end
      end
    end else begin : g_nofrac
      logic unused_frac;
      assign unused_frac = ^BAUD_FRAC;
      assign carry       = 1'b0;
    end
  endgenerate

  // Sync wins over a coincident divider event and reloads without a tick.
  always_comb begin
    cnt_nxt  = cnt;
    ovs_nxt  = ovs;
    tick_nxt = 1'b0;
    xmit_nxt = 1'b0;
    if (sync_load) begin
      cnt_nxt = {1'b0, BAUD_VAL};
      ovs_nxt = '0;
    end else if (div_event) begin
      cnt_nxt  = {1'b0, BAUD_VAL} + CW'(carry);
      ovs_nxt  = ovs + OVS_LOG2'(1);
      tick_nxt = 1'b1;
      xmit_nxt = &ovs;
    end else if (EN) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt    <= '0;
      ovs    <= '0;
      tick_r <= 1'b0;
      xmit_r <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      ovs    <= ovs_nxt;
      tick_r <= tick_nxt;
      xmit_r <= xmit_nxt;
    end
  end

  assign BAUD_TICK  = tick_r;
  assign XMIT_PULSE = xmit_r;
  assign OVS_PHASE  = ovs;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed plus randomized bench for uart_baud_gen against a timeline model
// that schedules the next tick by enabled-edge number.
module tb_uart_baud_gen;

  localparam int BW = 16;
  localparam int FW = 3;
  localparam int OL = 4;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          EN;
  logic          OVS_SYNC;
  logic [BW-1:0] BAUD_VAL;
  logic [FW-1:0] BAUD_FRAC;
  logic          BAUD_TICK;
  logic          XMIT_PULSE;
  logic [OL-1:0] OVS_PHASE;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: count enabled edges, remember which one fires the next tick.
  int   en_edges;
  int   due;
  int   acc_m;
  int   ticks;
  logic exp_tick;
  logic exp_xmit;

  always #5 CLK = ~CLK;

  uart_baud_gen #(
    .BAUD_WIDTH(BW),
    .FRAC_WIDTH(FW),
    .OVS_LOG2  (OL)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .EN        (EN),
    .BAUD_VAL  (BAUD_VAL),
    .BAUD_FRAC (BAUD_FRAC),
    .OVS_SYNC  (OVS_SYNC),
    .BAUD_TICK (BAUD_TICK),
    .XMIT_PULSE(XMIT_PULSE),
    .OVS_PHASE (OVS_PHASE)
  );

  function automatic void model_reset();
    en_edges = 0;
    due      = 1;
    acc_m    = 0;
    ticks    = 0;
    exp_tick = 1'b0;
    exp_xmit = 1'b0;
  endfunction

  function automatic void model_edge(input logic en_i, input logic sync_i,
                                     input int v, input int f);
    int s;
    exp_tick = 1'b0;
    exp_xmit = 1'b0;
    if (en_i) begin
      en_edges++;
      if (sync_i) begin
        due   = en_edges + v + 1;
        acc_m = 0;
        ticks = 0;
      end else if (en_edges == due) begin
        s        = acc_m + f;
        acc_m    = s % (1 << FW);
        due      = en_edges + v + (s >> FW) + 1;
        ticks++;
        exp_tick = 1'b1;
        exp_xmit = ((ticks % (1 << OL)) == 0);
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic en_i, input logic sync_i);
    EN       = en_i;
    OVS_SYNC = sync_i;
    @(posedge CLK);
    model_edge(en_i, sync_i, int'(BAUD_VAL), int'(BAUD_FRAC));
    #1;
    check("baud_tick", 32'(BAUD_TICK), 32'(exp_tick));
    check("xmit_pulse", 32'(XMIT_PULSE), 32'(exp_xmit));
    check("ovs_phase", 32'(OVS_PHASE), 32'(ticks % (1 << OL)));
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  int tick_cyc[$];
  int cyc;
  int guard;
  int n_t;
  int n_x;
  int exp_sp[8] = '{4, 4, 5, 4, 4, 5, 4, 5};

  initial begin
    RESET_N   = 1'b0;
    EN        = 1'b0;
    OVS_SYNC  = 1'b0;
    BAUD_VAL  = '0;
    BAUD_FRAC = '0;
    model_reset();
    #1;
    check("reset_tick", 32'(BAUD_TICK), 32'd0);
    check("reset_xmit", 32'(XMIT_PULSE), 32'd0);
    check("reset_phase", 32'(OVS_PHASE), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;

    // Integer divide V=3: first tick right after the first enabled edge.
    BAUD_VAL = 16'd3;
    step(1'b1, 1'b0);
    check("first_tick_after_reset", 32'(BAUD_TICK), 32'd1);
    n_x = 0;
    for (int i = 0; i < 128; i++) begin
      step(1'b1, 1'b0);
      if (XMIT_PULSE) n_x++;
    end
    check("int_div_xmit_per_128", 32'(n_x), 32'd2);

    // Fractional divide V=3, F=3 from a clean sync.
    BAUD_FRAC = 3'd3;
    step(1'b1, 1'b1);
    tick_cyc.delete();
    cyc   = 0;
    guard = 0;
    while (tick_cyc.size() < 9 && guard < 200) begin
      step(1'b1, 1'b0);
      cyc++;
      guard++;
      if (BAUD_TICK) tick_cyc.push_back(cyc);
    end
    check("frac_ticks_seen", 32'(tick_cyc.size()), 32'd9);
    if (tick_cyc.size() == 9) begin
      check("frac_first_after_sync", 32'(tick_cyc[0]), 32'd4);
      for (int i = 0; i < 8; i++)
        check($sformatf("frac_spacing_%0d", i), 32'(tick_cyc[i+1] - tick_cyc[i]), 32'(exp_sp[i]));
      check("frac_span_8_ticks", 32'(tick_cyc[8] - tick_cyc[0]), 32'd35);
    end
    run(40);

    // Minimum divisor: tick every enabled cycle.
    BAUD_VAL  = 16'd0;
    BAUD_FRAC = 3'd0;
    step(1'b1, 1'b1);
    n_t = 0;
    n_x = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0);
      if (BAUD_TICK) n_t++;
      if (XMIT_PULSE) n_x++;
    end
    check("min_div_ticks", 32'(n_t), 32'd32);
    check("min_div_xmit", 32'(n_x), 32'd2);

    // Enable gating mid-count at V=7.
    BAUD_VAL = 16'd7;
    step(1'b1, 1'b1);
    run(11);
    repeat (10) step(1'b0, 1'b0);
    run(25);

    // Resync at phase 9 with three edges to go (count of 2), V=5.
    BAUD_VAL = 16'd5;
    step(1'b1, 1'b1);
    guard = 0;
    while (!(ticks == 9 && due - en_edges == 3) && guard < 300) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("resync_target_reached", 32'(ticks == 9 && due - en_edges == 3), 32'd1);
    step(1'b1, 1'b1);
    check("resync_phase_zero", 32'(OVS_PHASE), 32'd0);
    cyc   = 0;
    guard = 0;
    do begin
      step(1'b1, 1'b0);
      cyc++;
      guard++;
    end while (!BAUD_TICK && guard < 50);
    check("resync_first_tick_edges", 32'(cyc), 32'd6);
    run(100);

    // Sync coincident with a divider event: no tick.
    guard = 0;
    while (due != en_edges + 1 && guard < 20) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("coincident_target_reached", 32'(due == en_edges + 1), 32'd1);
    step(1'b1, 1'b1);
    check("coincident_no_tick", 32'(BAUD_TICK), 32'd0);
    run(20);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) BAUD_VAL = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) BAUD_FRAC = 3'($urandom_range(0, 7));
      step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset right after a tick, away from the clock edge.
    BAUD_VAL  = 16'd2;
    BAUD_FRAC = 3'd0;
    guard = 0;
    do begin
      step(1'b1, 1'b0);
      guard++;
    end while (!(BAUD_TICK && OVS_PHASE != 0) && guard < 100);
    RESET_N = 1'b0;
    #1;
    check("async_reset_tick", 32'(BAUD_TICK), 32'd0);
    check("async_reset_xmit", 32'(XMIT_PULSE), 32'd0);
    check("async_reset_phase", 32'(OVS_PHASE), 32'd0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();

    // Extreme divisor with a carry: build acc=7, then reload all-ones plus carry.
    BAUD_VAL  = 16'd0;
    BAUD_FRAC = 3'd7;
    step(1'b1, 1'b0);
    BAUD_VAL = 16'hFFFF;
    step(1'b1, 1'b0);
    check("max_carry_reload_tick", 32'(BAUD_TICK), 32'd1);
    cyc   = 0;
    guard = 0;
    do begin
      step(1'b1, 1'b0);
      cyc++;
      guard++;
    end while (!BAUD_TICK && guard < 70000);
    check("max_carry_period", 32'(cyc), 32'd65537);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud-rate generator for the CoreUART family, succeeding the fixed 13-bit, 3-bit-fraction clock generator. It divides the system clock by a programmable integer-plus-fraction value to produce an oversample tick. It also produces a transmit bit pulse every 2^OVS_LOG2 ticks. A receiver-driven resync input restarts the divider and oversample phase so RX sampling aligns to a start-bit edge. It sits between the APB register block, which supplies the baud value, and the UART TX/RX state machines.

## Interface
- BAUD_WIDTH, 16: width of the integer divisor BAUD_VAL (2..24).
- FRAC_WIDTH, 3: width of the fractional divisor BAUD_FRAC, in units of 1/2^FRAC_WIDTH (0..8). 0 disables the fraction logic.
- OVS_LOG2, 4: log2 of the oversample ratio; 4 gives x16.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- EN  in  1  generator enable; when low, all state holds.
- BAUD_VAL  in  BAUD_WIDTH  integer divisor V; tick period is V+1 cycles.
- BAUD_FRAC  in  FRAC_WIDTH  fractional divisor F; adds F/2^FRAC_WIDTH cycles to the average period.
- OVS_SYNC  in  1  one-cycle request to restart the divider and the oversample phase.
- BAUD_TICK  out  1  registered one-cycle oversample tick.
- XMIT_PULSE  out  1  registered one-cycle bit pulse, coincident with every 2^OVS_LOG2-th BAUD_TICK.
- OVS_PHASE  out  OVS_LOG2  current oversample phase counter.

## Operation
- State:
  - cnt: BAUD_WIDTH+1 bits, a down counter.
  - acc: FRAC_WIDTH bits, the fraction accumulator.
  - ovs: OVS_LOG2 bits, the oversample phase.
  - tick_r and xmit_r: output registers.
- Reset (RESET_N low) clears cnt, acc, ovs, tick_r and xmit_r to 0 immediately. BAUD_TICK, XMIT_PULSE and OVS_PHASE therefore read 0 during reset.
- A divider event occurs on an edge when EN=1, OVS_SYNC=0 and cnt==0. On that edge:
  - {carry, sum} = acc + BAUD_FRAC, computed FRAC_WIDTH+1 bits wide.
  - cnt <= BAUD_VAL + carry, zero-extended into BAUD_WIDTH+1 bits so it never overflows.
  - acc <= sum.
  - tick_r <= 1.
  - ovs <= ovs+1, wrapping from all-ones to 0.
  - xmit_r <= 1 if ovs was all-ones, else 0.
- On an edge with EN=1, OVS_SYNC=0 and cnt!=0: cnt <= cnt-1; tick_r <= 0; xmit_r <= 0.
- On an edge with EN=1 and OVS_SYNC=1, regardless of cnt:
  - cnt <= BAUD_VAL; acc <= 0; ovs <= 0.
  - tick_r <= 0; xmit_r <= 0.
  - OVS_SYNC has priority over a coincident divider event; no tick is produced.
- On an edge with EN=0: cnt, acc and ovs hold; tick_r <= 0; xmit_r <= 0. OVS_SYNC is ignored.
- BAUD_VAL and BAUD_FRAC changes take effect at the next reload (divider event or OVS_SYNC). The current count is not truncated.
- When FRAC_WIDTH=0, the carry is constantly 0 and no acc register is built.

## Timing
- Ticks: BAUD_TICK is high exactly one cycle, in the cycle after each event edge.
- Tick spacing: V+1 cycles, or V+2 when the reload took a carry.
- Average period over 2^FRAC_WIDTH ticks: V+1+F/2^FRAC_WIDTH cycles.
- First tick after reset: the first enabled edge sees cnt==0, so BAUD_TICK is high in the cycle after that edge.
- First tick after OVS_SYNC: OVS_SYNC behaves as a silent event. The first tick follows the edge V+1 edges after the sync edge, or later if EN drops in between.
- XMIT_PULSE:
  - Always coincides with a BAUD_TICK.
  - The first one after reset or sync is the 2^OVS_LOG2-th tick.
  - It occurs on the same cycle OVS_PHASE changes from all-ones to 0.
- OVS_PHASE updates on the event edge, in the same cycle BAUD_TICK is high.
- V=0, F=0 makes BAUD_TICK high on every enabled cycle.
- V=2^BAUD_WIDTH-1 with a carry gives a period of 2^BAUD_WIDTH+1 cycles with no wrap.

## Test plan
- Integer divide: V=3, F=0, EN=1 after reset.
  - BAUD_TICK on cycles 1, 5, 9, …
  - XMIT_PULSE every 64 cycles, on ticks 16, 32, …
  - OVS_PHASE runs 1..15, 0.
- Fractional divide: V=3, F=3, FRAC_WIDTH=3.
  - Tick spacings repeat 4,4,5,4,4,5,4,5: 35 cycles per 8 ticks.
  - acc returns to 0 after the 8th tick.
- Minimum divisor: V=0, F=0.
  - BAUD_TICK high continuously.
  - XMIT_PULSE high one cycle in every 16.
- Enable gating: drop EN for 10 cycles mid-count at V=7.
  - Outputs 0 while EN is low.
  - On re-enable, the next tick arrives after exactly the remaining count, with OVS_PHASE unchanged.
- Resync:
  - Pulse OVS_SYNC at ovs=9 with cnt=2, V=5. Required: OVS_PHASE=0, the next tick 6 edges later, XMIT_PULSE on the 16th tick after the sync.
  - Repeat with OVS_SYNC coincident with cnt==0. Required: no tick on that edge.
- Reset and extremes:
  - Assert RESET_N low asynchronously mid-period. All outputs go to 0 before the next CLK edge.
  - Then set V=all-ones, F=all-ones. The first carry period equals 2^BAUD_WIDTH+1 cycles.
